// File: rtl/instr_fetch.sv
// Instruction fetch unit: IDLE -> REQ -> EXEC sequencer that reads one
// instruction word per fetch, latches it into ir and precomputes the branch
// target. Optional fetch-timeout watchdog is enabled by defining
// FETCH_TIMEOUT_EN; without it REQ waits indefinitely and fault is tied to 0.
module instr_fetch #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter logic [15:0] NOP_WORD       = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] ir,
    output logic        ir_valid,
    output logic        pc_advance,
    output logic [15:0] branch_offset,
    output logic        fault
);

    localparam int unsigned W     = 16;
    localparam int unsigned OFF_W = 9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_EXEC = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic         capture_c;
    logic         timeout_c;
    logic [W-1:0] offset_sext_c;

    assign capture_c     = (state == S_REQ) && imem_ack;
    assign offset_sext_c = {{(W-OFF_W){imem_rdata[OFF_W-1]}}, imem_rdata[OFF_W-1:0]};

    // The PC controller holds pc stable between pc_advance strobes, so the
    // address is a straight feed-through of pc.
    assign imem_addr = pc;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0] tmo_cnt;

    assign timeout_c = (state == S_REQ) && !imem_ack &&
                       (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count consecutive unacknowledged REQ cycles; fault is sticky until reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            tmo_cnt <= '0;
            fault   <= 1'b0;
        end else begin
            if ((state == S_REQ) && !imem_ack && !timeout_c) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end else begin
                tmo_cnt <= '0;
            end
            if (timeout_c) begin
                fault <= 1'b1;
            end
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^{NOP_WORD, 8'(TIMEOUT_CYCLES)};
    assign timeout_c  = 1'b0;
    assign fault      = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_REQ;
            S_REQ:   if (capture_c || timeout_c) state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_REQ;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the state register only.
    always_comb begin
        imem_req   = 1'b0;
        ir_valid   = 1'b0;
        pc_advance = 1'b0;
        case (state)
            S_REQ:  imem_req = 1'b1;
            S_EXEC: begin
                ir_valid   = 1'b1;
                pc_advance = 1'b1;
            end
            default: ;
        endcase
    end

    // Instruction and branch-target capture; an ack beats a same-edge timeout.
    always_ff @(posedge clock) begin
        if (reset) begin
            ir            <= '0;
            branch_offset <= '0;
        end else if (capture_c) begin
            ir            <= imem_rdata;
            branch_offset <= pc + W'(1) + offset_sext_c;
        end else if (timeout_c) begin
            ir            <= NOP_WORD;
            branch_offset <= pc + W'(1);
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned TO     = 3;
    localparam int          WAIT_N = 2;
`else
    localparam int unsigned TO     = 15;
    localparam int          WAIT_N = 5;
`endif
    localparam logic [15:0] NOP = 16'h0000;

    logic        clock;
    logic        reset;
    logic [15:0] pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] ir;
    logic        ir_valid;
    logic        pc_advance;
    logic [15:0] branch_offset;
    logic        fault;

    int checks = 0;
    int passed = 0;

    instr_fetch #(
        .TIMEOUT_CYCLES(TO),
        .NOP_WORD      (NOP)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .pc           (pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .ir           (ir),
        .ir_valid     (ir_valid),
        .pc_advance   (pc_advance),
        .branch_offset(branch_offset),
        .fault        (fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        imem_ack = 1'b0;
        imem_rdata = 16'h0;
        pc = 16'h0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Branch target from the rules: pc + 1 + signed 9-bit offset, wrapped to 16 bits.
    function automatic logic [15:0] target(input logic [15:0] p, input logic [15:0] d);
        int off;
        logic [8:0] f;
        f = d[8:0];
        off = f[8] ? int'(f) - 512 : int'(f);
        return 16'((int'(p) + 1 + off) % 65536);
    endfunction

    task automatic test_reset();
        do_reset();
        checks++; if (imem_req !== 1'b0) $display("FAIL reset_req got %b want 0", imem_req); else passed++;
        checks++; if (ir_valid !== 1'b0 || pc_advance !== 1'b0) $display("FAIL reset_strobes got %b%b want 00", ir_valid, pc_advance); else passed++;
        checks++; if (ir !== 16'h0) $display("FAIL reset_ir got %h want 0000", ir); else passed++;
        checks++; if (branch_offset !== 16'h0) $display("FAIL reset_bo got %h want 0000", branch_offset); else passed++;
        checks++; if (fault !== 1'b0) $display("FAIL reset_fault got %b want 0", fault); else passed++;
    endtask

    task automatic test_stream();
        do_reset();
        imem_ack = 1'b1;
        imem_rdata = 16'h1234;
        step();
        checks++; if (imem_req !== 1'b1 || ir_valid !== 1'b0) $display("FAIL stream_c1 got req=%b v=%b want req=1 v=0", imem_req, ir_valid); else passed++;
        step();
        checks++; if (ir !== 16'h1234 || ir_valid !== 1'b1 || pc_advance !== 1'b1 || imem_req !== 1'b0)
            $display("FAIL stream_c2 got ir=%h v=%b adv=%b req=%b want 1234 1 1 0", ir, ir_valid, pc_advance, imem_req); else passed++;
        for (int k = 3; k <= 8; k++) begin
            step();
            checks++; if (imem_req !== k[0] || ir_valid !== !k[0])
                $display("FAIL stream_c%0d got req=%b v=%b want req=%b v=%b", k, imem_req, ir_valid, k[0], !k[0]); else passed++;
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_branch();
        do_reset();
        pc = 16'h0010;
        step();
        imem_ack = 1'b1;
        imem_rdata = 16'h01FE;
        step();
        checks++; if (branch_offset !== 16'h000F) $display("FAIL branch_neg got %h want 000F", branch_offset); else passed++;
        imem_ack = 1'b0;
        step();
        pc = 16'hFFFF;
        step();
        checks++; if (ir !== 16'h01FE || branch_offset !== 16'h000F) $display("FAIL branch_hold got ir=%h bo=%h want 01FE 000F", ir, branch_offset); else passed++;
        imem_ack = 1'b1;
        imem_rdata = 16'h0000;
        step();
        checks++; if (branch_offset !== 16'h0000) $display("FAIL branch_wrap got %h want 0000", branch_offset); else passed++;
        imem_ack = 1'b0;
    endtask

    task automatic test_wait();
        int pulses;
        do_reset();
        pc = 16'h0042;
        step();
        for (int j = 0; j < WAIT_N; j++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0042 || ir !== 16'h0 || ir_valid !== 1'b0)
                $display("FAIL wait_c%0d got req=%b addr=%h ir=%h v=%b want 1 0042 0000 0", j, imem_req, imem_addr, ir, ir_valid); else passed++;
            step();
        end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0042) $display("FAIL wait_ackcyc got req=%b addr=%h want 1 0042", imem_req, imem_addr); else passed++;
        imem_ack = 1'b1;
        imem_rdata = 16'hBEEF;
        step();
        imem_ack = 1'b0;
        pulses = 0;
        for (int j = 0; j < 4; j++) begin
            if (ir_valid === 1'b1) pulses++;
            step();
        end
        checks++; if (pulses !== 1) $display("FAIL wait_pulses got %0d want 1", pulses); else passed++;
        checks++; if (ir !== 16'hBEEF) $display("FAIL wait_ir got %h want BEEF", ir); else passed++;
    endtask

    task automatic test_reset_midfetch();
        do_reset();
        step();
        imem_ack = 1'b1;
        imem_rdata = 16'hABCD;
        step();
        imem_ack = 1'b0;
        step();
        reset = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 16'h1357;
        step();
        checks++; if (ir !== 16'h0 || branch_offset !== 16'h0 || imem_req !== 1'b0 || ir_valid !== 1'b0)
            $display("FAIL midreset got ir=%h bo=%h req=%b v=%b want 0000 0000 0 0", ir, branch_offset, imem_req, ir_valid); else passed++;
        reset = 1'b0;
        step();
        checks++; if (imem_req !== 1'b1 || ir !== 16'h0) $display("FAIL idle_ack got req=%b ir=%h want 1 0000", imem_req, ir); else passed++;
        imem_rdata = 16'h5555;
        step();
        checks++; if (ir !== 16'h5555 || ir_valid !== 1'b1) $display("FAIL capture_after got ir=%h v=%b want 5555 1", ir, ir_valid); else passed++;
        imem_rdata = 16'h7777;
        step();
        checks++; if (ir !== 16'h5555 || ir_valid !== 1'b0 || imem_req !== 1'b1)
            $display("FAIL exec_ack got ir=%h v=%b req=%b want 5555 0 1", ir, ir_valid, imem_req); else passed++;
        imem_ack = 1'b0;
    endtask

    // Random acks/data against a transaction-level model of the fetch loop.
    task automatic test_random();
        bit m_req, m_exec, was_exec;
        logic [15:0] e_ir, e_bo;
        bit e_fault;
        int waited;
        int errs;
        do_reset();
        m_req = 0; m_exec = 0; e_ir = 16'h0; e_bo = 16'h0; e_fault = 0; waited = 0; errs = 0;
        for (int i = 0; i < 400; i++) begin
            imem_ack = ($urandom_range(0, 2) != 0);
            imem_rdata = 16'($urandom);
            was_exec = m_exec;
            if (m_req) begin
                if (imem_ack) begin
                    e_ir = imem_rdata; e_bo = target(pc, imem_rdata);
                    m_req = 0; m_exec = 1;
                end else begin
                    waited++;
`ifdef FETCH_TIMEOUT_EN
                    if (waited == int'(TO)) begin
                        e_ir = NOP; e_bo = 16'((int'(pc) + 1) % 65536); e_fault = 1;
                        m_req = 0; m_exec = 1;
                    end
`endif
                end
            end else begin
                m_req = 1; m_exec = 0; waited = 0;
            end
            step();
            if (was_exec) pc = 16'($urandom);
            checks++;
            if (imem_req !== m_req || ir_valid !== m_exec || pc_advance !== m_exec || ir !== e_ir ||
                branch_offset !== e_bo || fault !== e_fault || (imem_req === 1'b1 && imem_addr !== pc)) begin
                if (errs < 10)
                    $display("FAIL random_c%0d got req=%b v=%b adv=%b ir=%h bo=%h f=%b want %b %b %b %h %h %b",
                             i, imem_req, ir_valid, pc_advance, ir, branch_offset, fault, m_req, m_exec, m_exec, e_ir, e_bo, e_fault);
                errs++;
            end else passed++;
        end
        imem_ack = 1'b0;
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        pc = 16'h0100;
        step();
        imem_ack = 1'b1;
        imem_rdata = 16'h1111;
        step();
        imem_ack = 1'b0;
        step();
        step();
        step();
        checks++; if (ir_valid !== 1'b0 || fault !== 1'b0) $display("FAIL tmo_early got v=%b f=%b want 0 0", ir_valid, fault); else passed++;
        step();
        checks++; if (ir !== NOP || fault !== 1'b1 || ir_valid !== 1'b1 || branch_offset !== 16'h0101)
            $display("FAIL tmo_fire got ir=%h f=%b v=%b bo=%h want %h 1 1 0101", ir, fault, ir_valid, branch_offset, NOP); else passed++;
        step();
        imem_ack = 1'b1;
        imem_rdata = 16'h2222;
        step();
        imem_ack = 1'b0;
        checks++; if (ir !== 16'h2222 || fault !== 1'b1) $display("FAIL tmo_sticky got ir=%h f=%b want 2222 1", ir, fault); else passed++;
        do_reset();
        checks++; if (fault !== 1'b0) $display("FAIL tmo_clear got f=%b want 0", fault); else passed++;
        step();
        step();
        step();
        imem_ack = 1'b1;
        imem_rdata = 16'h3333;
        step();
        imem_ack = 1'b0;
        checks++; if (ir !== 16'h3333 || fault !== 1'b0 || ir_valid !== 1'b1)
            $display("FAIL tmo_ackwins got ir=%h f=%b v=%b want 3333 0 1", ir, fault, ir_valid); else passed++;
    endtask
`endif

    initial begin
        reset = 1'b1;
        pc = 16'h0;
        imem_ack = 1'b0;
        imem_rdata = 16'h0;
        test_reset();
        test_stream();
        test_branch();
        test_wait();
        test_reset_midfetch();
`ifdef FETCH_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
